// File: rtl/slave_ram_arbiter.sv
// rtl/slave_ram_arbiter.sv - round-robin arbiter sharing one main slave RAM channel between two requesters
//
// Ports:
//   clock, reset              single clock, synchronous active-high reset
//   lock                      blocks new grants; in-flight transactions still complete
//   rqN_valid/ready/we/addr/wdata/size   requester N command (ready is combinational)
//   rsN_valid/data            one-cycle response pulse to requester N (data 0 for writes)
//   S_oe_ram/S_we_ram/S_addr_ram/S_Wdata_ram/S_data_ram_size   registered strobe to main
//   Sout_Rdata_ram/Sout_DataRdy                                completion from main
//   err                       sticky error flag, cleared only by reset
//   outstanding               tag FIFO occupancy
//
// Optional feature: define SLAVE_ARB_WATCHDOG_EN to retire a transaction that waits
// WDOG_CYCLES without completion (response data 0, err set).
module slave_ram_arbiter #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 64,
    parameter int SIZE_W       = 7,
    parameter int TAG_DEPTH    = 4,
    parameter int DRAIN_CYCLES = 8,
    parameter int WDOG_CYCLES  = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         lock,
    input  logic                         rq0_valid,
    output logic                         rq0_ready,
    input  logic                         rq0_we,
    input  logic [ADDR_W-1:0]            rq0_addr,
    input  logic [DATA_W-1:0]            rq0_wdata,
    input  logic [SIZE_W-1:0]            rq0_size,
    input  logic                         rq1_valid,
    output logic                         rq1_ready,
    input  logic                         rq1_we,
    input  logic [ADDR_W-1:0]            rq1_addr,
    input  logic [DATA_W-1:0]            rq1_wdata,
    input  logic [SIZE_W-1:0]            rq1_size,
    output logic                         rs0_valid,
    output logic [DATA_W-1:0]            rs0_data,
    output logic                         rs1_valid,
    output logic [DATA_W-1:0]            rs1_data,
    output logic                         S_oe_ram,
    output logic                         S_we_ram,
    output logic [ADDR_W-1:0]            S_addr_ram,
    output logic [DATA_W-1:0]            S_Wdata_ram,
    output logic [SIZE_W-1:0]            S_data_ram_size,
    input  logic [DATA_W-1:0]            Sout_Rdata_ram,
    input  logic                         Sout_DataRdy,
    output logic                         err,
    output logic [$clog2(TAG_DEPTH):0]   outstanding
);
    localparam int PTR_W   = $clog2(TAG_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int DRAIN_W = ($clog2(DRAIN_CYCLES + 1) > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    // Each tag entry is {requester id, we}; we decides whether the response carries data.
    logic [1:0]         tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               last_id;
    logic [DRAIN_W-1:0] drain_cnt;

    logic               fifo_full;
    logic               fifo_empty;
    logic               grant_ok;
    logic               winner;
    logic               push;
    logic               rdy_pop;
    logic               wdog_pop;
    logic               pop;
    logic               stray;
    logic               drain_active;
    logic               acc_we;
    logic [ADDR_W-1:0]  acc_addr;
    logic [DATA_W-1:0]  acc_wdata;
    logic [SIZE_W-1:0]  acc_size;
    logic               head_id;
    logic               head_we;
    logic [DATA_W-1:0]  resp_data;

    assign fifo_full    = (count == CNT_W'(TAG_DEPTH));
    assign fifo_empty   = (count == '0);
    assign grant_ok     = !lock && !fifo_full && !reset;
    assign drain_active = (drain_cnt < DRAIN_W'(DRAIN_CYCLES));

    // Lone requester wins; under contention the one not served last wins.
    always_comb begin
        winner = 1'b0;
        if (rq0_valid && rq1_valid) begin
            winner = ~last_id;
        end else if (rq1_valid) begin
            winner = 1'b1;
        end
    end

    assign rq0_ready = grant_ok && rq0_valid && !winner;
    assign rq1_ready = grant_ok && rq1_valid && winner;
    assign push      = rq0_ready || rq1_ready;

    assign acc_we    = winner ? rq1_we    : rq0_we;
    assign acc_addr  = winner ? rq1_addr  : rq0_addr;
    assign acc_wdata = winner ? rq1_wdata : rq0_wdata;
    assign acc_size  = winner ? rq1_size  : rq0_size;

    assign head_id   = tag_mem[rd_ptr][1];
    assign head_we   = tag_mem[rd_ptr][0];
    assign rdy_pop   = Sout_DataRdy && !fifo_empty;
    assign stray     = Sout_DataRdy && fifo_empty;
    assign pop       = rdy_pop || wdog_pop;
    // A watchdog retirement returns 0, as does any write completion.
    assign resp_data = (rdy_pop && !head_we) ? Sout_Rdata_ram : '0;

`ifdef SLAVE_ARB_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_cnt;

    assign wdog_pop = !fifo_empty && !Sout_DataRdy && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || fifo_empty || pop) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end
`else
    assign wdog_pop = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem[wr_ptr] <= {winner, acc_we};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            last_id         <= 1'b1;
            drain_cnt       <= '0;
            err             <= 1'b0;
            S_oe_ram        <= 1'b0;
            S_we_ram        <= 1'b0;
            S_addr_ram      <= '0;
            S_Wdata_ram     <= '0;
            S_data_ram_size <= '0;
            rs0_valid       <= 1'b0;
            rs1_valid       <= 1'b0;
            rs0_data        <= '0;
            rs1_data        <= '0;
        end else begin
            S_oe_ram        <= push && !acc_we;
            S_we_ram        <= push && acc_we;
            S_addr_ram      <= push ? acc_addr  : '0;
            S_Wdata_ram     <= push ? acc_wdata : '0;
            S_data_ram_size <= push ? acc_size  : '0;

            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                last_id <= winner;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            rs0_valid <= pop && !head_id;
            rs1_valid <= pop && head_id;
            rs0_data  <= (pop && !head_id) ? resp_data : '0;
            rs1_data  <= (pop && head_id)  ? resp_data : '0;

            // Completions arriving shortly after reset belong to transactions
            // that reset discarded, so they are not errors.
            if (drain_active) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
            if ((stray && !drain_active) || wdog_pop) begin
                err <= 1'b1;
            end
        end
    end

    assign outstanding = count;
endmodule

// File: tb/tb_slave_ram_arbiter.sv
// tb/tb_slave_ram_arbiter.sv - randomized self-checking bench for slave_ram_arbiter
module tb_slave_ram_arbiter;
    localparam int ADDR_W       = 9;
    localparam int DATA_W       = 64;
    localparam int SIZE_W       = 7;
    localparam int TAG_DEPTH    = 4;
    localparam int DRAIN_CYCLES = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset, lock;
    logic              rq0_valid, rq0_ready, rq0_we;
    logic [ADDR_W-1:0] rq0_addr;
    logic [DATA_W-1:0] rq0_wdata;
    logic [SIZE_W-1:0] rq0_size;
    logic              rq1_valid, rq1_ready, rq1_we;
    logic [ADDR_W-1:0] rq1_addr;
    logic [DATA_W-1:0] rq1_wdata;
    logic [SIZE_W-1:0] rq1_size;
    logic              rs0_valid, rs1_valid;
    logic [DATA_W-1:0] rs0_data, rs1_data;
    logic              S_oe_ram, S_we_ram;
    logic [ADDR_W-1:0] S_addr_ram;
    logic [DATA_W-1:0] S_Wdata_ram;
    logic [SIZE_W-1:0] S_data_ram_size;
    logic [DATA_W-1:0] Sout_Rdata_ram;
    logic              Sout_DataRdy;
    logic              err;
    logic [$clog2(TAG_DEPTH):0] outstanding;

    slave_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
        .TAG_DEPTH(TAG_DEPTH), .DRAIN_CYCLES(DRAIN_CYCLES), .WDOG_CYCLES(64)
    ) dut (
        .clock(clock), .reset(reset), .lock(lock),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_we(rq0_we),
        .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rq0_size(rq0_size),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_we(rq1_we),
        .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rq1_size(rq1_size),
        .rs0_valid(rs0_valid), .rs0_data(rs0_data),
        .rs1_valid(rs1_valid), .rs1_data(rs1_data),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
        .err(err), .outstanding(outstanding)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: queue of outstanding owners plus the outputs expected next cycle.
    int          m_id[$];
    bit          m_we[$];
    int          last_id;
    bit          m_err;
    int          since_reset;
    bit          e_oe, e_we, e_rs0v, e_rs1v;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_rs0d, e_rs1d;
    logic [SIZE_W-1:0] e_size;

    task automatic model_reset();
        m_id.delete();
        m_we.delete();
        last_id = 1; m_err = 0; since_reset = 0;
        e_oe = 0; e_we = 0; e_rs0v = 0; e_rs1v = 0;
        e_addr = '0; e_wdata = '0; e_size = '0; e_rs0d = '0; e_rs1d = '0;
    endtask

    task automatic set(input bit v0, input bit v1, input bit lk, input bit dr, input bit rst);
        rq0_valid = v0; rq1_valid = v1; lock = lk; Sout_DataRdy = dr; reset = rst;
        rq0_we = 1'($urandom); rq1_we = 1'($urandom);
        rq0_addr = ADDR_W'($urandom); rq1_addr = ADDR_W'($urandom);
        rq0_wdata = {$urandom, $urandom}; rq1_wdata = {$urandom, $urandom};
        rq0_size = SIZE_W'($urandom); rq1_size = SIZE_W'($urandom);
        Sout_Rdata_ram = {$urandom, $urandom};
    endtask

    // Called at a negedge with inputs applied; compares, advances the model, returns at next negedge.
    task automatic step();
        int  win, id;
        bit  ok, a0, a1, we;
        #1;
        ok = !lock && (m_id.size() < TAG_DEPTH) && !reset;
        if (rq0_valid && rq1_valid) win = (last_id == 0) ? 1 : 0;
        else                        win = rq1_valid ? 1 : 0;
        a0 = ok && rq0_valid && (win == 0);
        a1 = ok && rq1_valid && (win == 1);
        check("rq0_ready", rq0_ready, a0);
        check("rq1_ready", rq1_ready, a1);
        check("S_oe_ram", S_oe_ram, e_oe);
        check("S_we_ram", S_we_ram, e_we);
        check("S_addr_ram", S_addr_ram, e_addr);
        check("S_Wdata_ram", S_Wdata_ram, e_wdata);
        check("S_data_ram_size", S_data_ram_size, e_size);
        check("rs0_valid", rs0_valid, e_rs0v);
        check("rs1_valid", rs1_valid, e_rs1v);
        check("rs0_data", rs0_data, e_rs0d);
        check("rs1_data", rs1_data, e_rs1d);
        check("err", err, m_err);
        check("outstanding", outstanding, m_id.size());
        if (reset) begin
            model_reset();
        end else begin
            e_oe    = (a0 && !rq0_we) || (a1 && !rq1_we);
            e_we    = (a0 && rq0_we)  || (a1 && rq1_we);
            e_addr  = a0 ? rq0_addr  : a1 ? rq1_addr  : '0;
            e_wdata = a0 ? rq0_wdata : a1 ? rq1_wdata : '0;
            e_size  = a0 ? rq0_size  : a1 ? rq1_size  : '0;
            e_rs0v = 0; e_rs1v = 0; e_rs0d = '0; e_rs1d = '0;
            if (Sout_DataRdy) begin
                if (m_id.size() > 0) begin
                    id = m_id.pop_front();
                    we = m_we.pop_front();
                    if (id == 0) begin e_rs0v = 1; e_rs0d = we ? '0 : Sout_Rdata_ram; end
                    else         begin e_rs1v = 1; e_rs1d = we ? '0 : Sout_Rdata_ram; end
                end else if (since_reset >= DRAIN_CYCLES) begin
                    m_err = 1;
                end
            end
            if (a0) begin m_id.push_back(0); m_we.push_back(rq0_we); last_id = 0; end
            if (a1) begin m_id.push_back(1); m_we.push_back(rq1_we); last_id = 1; end
            since_reset++;
        end
        @(negedge clock);
    endtask

    task automatic drain();
        int guard = 0;
        while (m_id.size() > 0 && guard < 50) begin
            set(0, 0, 0, 1, 0); step();
            guard++;
        end
        check("drain_bound", guard < 50, 1'b1);
        set(0, 0, 0, 0, 0); step();
    endtask

    initial begin
        rq0_valid = 0; rq1_valid = 0; lock = 0; Sout_DataRdy = 0; reset = 1;
        set(0, 0, 0, 0, 1);
        repeat (3) @(negedge clock);
        model_reset();

        // reset values
        set(0, 0, 0, 0, 0); step();

        // single read of 0x010, data returns two cycles after the strobe
        set(1, 0, 0, 0, 0); rq0_we = 0; rq0_addr = 9'h010; step();
        set(0, 0, 0, 0, 0); step();
        set(0, 0, 0, 0, 0); step();
        set(0, 0, 0, 1, 0); Sout_Rdata_ram = 64'hDEAD; step();
        check("single_rs0_data", rs0_data, 64'hDEAD);
        set(0, 0, 0, 0, 0); step();

        // contention: grants alternate
        for (int i = 0; i < 6; i++) begin
            set(1, 1, 0, m_id.size() > 0, 0); step();
        end
        drain();

        // backpressure: four accepted, fifth waits for a completion
        for (int i = 0; i < 5; i++) begin
            set(1, 0, 0, 0, 0); step();
        end
        #1;
        check("bp_outstanding", outstanding, 4);
        check("bp_fifth_ready", rq0_ready, 1'b0);
        set(1, 0, 0, 1, 0); step();
        set(1, 0, 0, 0, 0); step();
        drain();

        // lock holds off a pending request
        for (int i = 0; i < 10; i++) begin
            set(0, 1, 1, 0, 0); step();
        end
        set(0, 1, 0, 0, 0); step();
        drain();

        // reset mid-operation, late completion dropped, later stray flagged
        set(1, 0, 0, 0, 0); rq0_we = 0; step();
        set(1, 0, 0, 0, 0); rq0_we = 0; step();
        set(0, 0, 0, 0, 1); step();
        set(0, 0, 0, 0, 0); step();
        set(0, 0, 0, 0, 0); step();
        set(0, 0, 0, 1, 0); step();
        #1;
        check("drain_window_err", err, 1'b0);
        for (int i = 3; i < 20; i++) begin
            set(0, 0, 0, 0, 0); step();
        end
        set(0, 0, 0, 1, 0); step();
        #1;
        check("stray_err", err, 1'b1);

        // without the watchdog an unanswered read stays outstanding
        set(0, 0, 0, 0, 1); step();
        set(1, 0, 0, 0, 0); rq0_we = 0; step();
        for (int i = 0; i < 70; i++) begin
            set(0, 0, 0, 0, 0); step();
        end
        #1;
        check("no_wdog_outstanding", outstanding, 1);
        drain();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit dr;
            dr = (m_id.size() > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 3);
            set(1'($urandom), 1'($urandom), $urandom_range(0, 99) < 10, dr,
                $urandom_range(0, 99) < 1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
